timer0_peripheral: RTL and testbench

- Timer0 (TMR0 + OPTION_REG) responder on the core's external peripheral bus.
- Decodes the 9-bit register-file address, accepts writes driven from the core's ALU output and returns read data on the peripheral read path.
- Counts instruction cycles or synchronised T0CKI pin edges through an optional 8-bit prescaler, and pulses an overflow flag-set request for the interrupt logic (INTCON.T0IF).

---
 rtl/timer0_peripheral_if.sv | 25 ++
 rtl/timer0_peripheral.sv | 113 +++++++++++
 tb/tb_timer0_peripheral.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer0_peripheral_if.sv
// Peripheral bus between the core and a register-file responder.
// The core drives address/write strobe; the responder returns read data and a hit flag.
interface timer0_peripheral_if;
    logic [8:0] periph_addr;
    logic [7:0] periph_wr_data;
    logic       periph_wr_en;
    logic [7:0] periph_rd_data;
    logic       periph_sel;

    modport master (
        output periph_addr,
        output periph_wr_data,
        output periph_wr_en,
        input  periph_rd_data,
        input  periph_sel
    );

    modport slave (
        input  periph_addr,
        input  periph_wr_data,
        input  periph_wr_en,
        output periph_rd_data,
        output periph_sel
    );
endinterface

// File: rtl/timer0_peripheral.sv
// Timer0 (TMR0 + OPTION_REG) responder: counts instruction cycles or synchronised
// T0CKI edges through an optional prescaler and pulses t0if_set on overflow.
module timer0_peripheral #(
    parameter logic [8:0] TMR0_ADDR_A   = 9'h001,
    parameter logic [8:0] TMR0_ADDR_B   = 9'h101,
    parameter logic [8:0] OPTION_ADDR_A = 9'h081,
    parameter logic [8:0] OPTION_ADDR_B = 9'h181
) (
    input  logic                 clk,
    input  logic                 rst,
    timer0_peripheral_if.slave   bus,
    input  logic                 instr_cycle_tick,
    input  logic                 t0cki,
    output logic                 t0if_set
);

    logic [7:0] tmr0_q;
    logic [7:0] option_q;
    logic [7:0] presc_q;
    logic [1:0] inhibit_q;
    logic [1:0] warm_q;
    logic       sync1_q;
    logic       sync2_q;
    logic       sync3_q;

    logic       hit_tmr;
    logic       hit_opt;
    logic       tmr_wr;
    logic       opt_wr;
    logic       t0cs;
    logic       t0se;
    logic       psa;
    logic [2:0] ps;
    logic [7:0] presc_mask;
    logic       pin_event;
    logic       src_event;
    logic       accept;
    logic       tmr_inc;

    assign hit_tmr = (bus.periph_addr == TMR0_ADDR_A) || (bus.periph_addr == TMR0_ADDR_B);
    assign hit_opt = (bus.periph_addr == OPTION_ADDR_A) || (bus.periph_addr == OPTION_ADDR_B);
    assign tmr_wr  = bus.periph_wr_en & hit_tmr;
    assign opt_wr  = bus.periph_wr_en & hit_opt;

    assign t0cs = option_q[5];
    assign t0se = option_q[4];
    assign psa  = option_q[3];
    assign ps   = option_q[2:0];

    // Ratio 2^(PS+1): mask is PS+1 low ones.
    assign presc_mask = 8'((9'd2 << ps) - 9'd1);

    // Edge detect is gated until the sync chain has been refilled after reset.
    assign pin_event = (warm_q == 2'd3) &
                       (t0se ? (~sync2_q & sync3_q) : (sync2_q & ~sync3_q));
    assign src_event = t0cs ? pin_event : instr_cycle_tick;
    assign accept    = src_event & ~tmr_wr & (inhibit_q == 2'd0);
    assign tmr_inc   = accept & (psa | ((presc_q & presc_mask) == presc_mask));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr0_q    <= 8'h00;
            option_q  <= 8'hFF;
            presc_q   <= 8'h00;
            inhibit_q <= 2'd0;
            warm_q    <= 2'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            t0if_set  <= 1'b0;
        end else begin
            sync1_q <= t0cki;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (warm_q != 2'd3)
                warm_q <= warm_q + 2'd1;

            t0if_set <= tmr_inc & (tmr0_q == 8'hFF);

            if (tmr_wr)
                tmr0_q <= bus.periph_wr_data;
            else if (tmr_inc)
                tmr0_q <= tmr0_q + 8'h01;

            if (tmr_wr || opt_wr)
                presc_q <= 8'h00;
            else if (accept && !psa)
                presc_q <= presc_q + 8'h01;

            // Inhibit drains on instruction cycles regardless of the selected source.
            if (tmr_wr)
                inhibit_q <= 2'd2;
            else if (instr_cycle_tick && (inhibit_q != 2'd0))
                inhibit_q <= inhibit_q - 2'd1;

            if (opt_wr)
                option_q <= bus.periph_wr_data;
        end
    end

    always_comb begin
        bus.periph_rd_data = 8'h00;
        bus.periph_sel     = 1'b0;
        if (hit_tmr) begin
            bus.periph_rd_data = tmr0_q;
            bus.periph_sel     = 1'b1;
        end else if (hit_opt) begin
            bus.periph_rd_data = option_q;
            bus.periph_sel     = 1'b1;
        end
    end

endmodule

// File: tb/tb_timer0_peripheral.sv
// Bench for timer0_peripheral: reset decode table, directed corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_timer0_peripheral;

    logic clk = 1'b0;
    logic rst;
    logic instr_cycle_tick;
    logic t0cki;
    logic t0if_set;

    timer0_peripheral_if bus ();

    timer0_peripheral dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .instr_cycle_tick (instr_cycle_tick),
        .t0cki            (t0cki),
        .t0if_set         (t0if_set)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] rd;
        logic       sel;
    } rd_vec_t;

    rd_vec_t tbl [7];

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    int m_tmr;
    int m_opt;
    int m_presc;
    int m_inh;
    int m_edges;
    bit m_if;
    bit m_log [$];

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_rd(input int a);
        if (a == 'h001 || a == 'h101) return m_tmr;
        if (a == 'h081 || a == 'h181) return m_opt;
        return 0;
    endfunction

    function automatic int model_sel(input int a);
        return (a == 'h001 || a == 'h101 || a == 'h081 || a == 'h181) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_tmr   = 0;
        m_opt   = 'hFF;
        m_presc = 0;
        m_inh   = 0;
        m_edges = 0;
        m_if    = 0;
        m_log.delete();
        m_log.push_back(1'b0);
    endtask

    // One rising clock edge: the pin sampled at edge k affects TMR0 at edge k+2,
    // and the first 3 edges after reset release never see a pin event.
    task automatic model_step(input int a, input int wd, input bit we, input bit tick, input bit pin);
        bit hit_t;
        bit hit_o;
        bit pin_ev;
        bit ev;
        bit inc;
        bit nw;
        bit od;
        int ratio;
        hit_t  = we && (a == 'h001 || a == 'h101);
        hit_o  = we && (a == 'h081 || a == 'h181);
        ratio  = 1 << ((m_opt & 7) + 1);
        pin_ev = 0;
        inc    = 0;
        m_edges++;
        if (m_edges >= 4) begin
            nw = m_log[m_edges - 2];
            od = m_log[m_edges - 3];
            pin_ev = ((m_opt >> 4) & 1) ? (od && !nw) : (nw && !od);
        end
        ev = ((m_opt >> 5) & 1) ? pin_ev : tick;
        if (!hit_t && m_inh == 0 && ev) begin
            if ((m_opt >> 3) & 1)
                inc = 1;
            else begin
                m_presc++;
                if (m_presc % ratio == 0) inc = 1;
            end
        end
        m_if = 0;
        if (inc) begin
            if (m_tmr == 255) begin
                m_tmr = 0;
                m_if  = 1;
            end else
                m_tmr++;
        end
        if (hit_t) begin
            m_tmr   = wd;
            m_presc = 0;
            m_inh   = 2;
        end else if (tick && m_inh > 0)
            m_inh--;
        if (hit_o) begin
            m_opt   = wd;
            m_presc = 0;
        end
        m_log.push_back(pin);
    endtask

    // Drive one clock of inputs; checks read path before the edge and t0if_set after.
    task automatic cycle(input logic [8:0] a, input logic [7:0] wd, input bit we,
                         input bit tick, input bit pin);
        @(negedge clk);
        bus.periph_addr    = a;
        bus.periph_wr_data = wd;
        bus.periph_wr_en   = we;
        instr_cycle_tick   = tick;
        t0cki              = pin;
        #1;
        chk("rd_data", {1'b0, bus.periph_rd_data}, 9'(model_rd(a)));
        chk("sel", {8'h00, bus.periph_sel}, 9'(model_sel(a)));
        @(posedge clk);
        model_step(a, wd, we, tick, pin);
        #1;
        chk("t0if_set", {8'h00, t0if_set}, {8'h00, m_if});
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        cycle(a, d, 1'b1, 1'b0, t0cki);
    endtask

    // One instruction cycle: a tick followed by three idle clocks, TMR0 address held.
    task automatic icyc(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(9'h001, 8'h00, 1'b0, 1'b1, t0cki);
            repeat (3) cycle(9'h001, 8'h00, 1'b0, 1'b0, t0cki);
        end
    endtask

    task automatic do_reset(input bit pin);
        @(negedge clk);
        rst              = 1'b0;
        t0cki            = pin;
        bus.periph_wr_en = 1'b0;
        instr_cycle_tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    logic [7:0] e2 [6];
    bit         rpin;
    int         r;
    logic [8:0] ra;
    logic [7:0] rwd;

    initial begin
        rst                = 1'b0;
        bus.periph_addr    = 9'h000;
        bus.periph_wr_data = 8'h00;
        bus.periph_wr_en   = 1'b0;
        instr_cycle_tick   = 1'b0;
        t0cki              = 1'b0;
        model_reset();

        tbl[0] = '{9'h081, 8'hFF, 1'b1};
        tbl[1] = '{9'h181, 8'hFF, 1'b1};
        tbl[2] = '{9'h001, 8'h00, 1'b1};
        tbl[3] = '{9'h101, 8'h00, 1'b1};
        tbl[4] = '{9'h005, 8'h00, 1'b0};
        tbl[5] = '{9'h000, 8'h00, 1'b0};
        tbl[6] = '{9'h1FF, 8'h00, 1'b0};
        e2 = '{8'hFD, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};

        // Reset-state decode
        do_reset(1'b0);
        chk("reset_t0if", {8'h00, t0if_set}, 9'h000);
        for (int i = 0; i < 7; i++) begin
            bus.periph_addr = tbl[i].addr;
            #1;
            chk("tbl_rd", {1'b0, bus.periph_rd_data}, {1'b0, tbl[i].rd});
            chk("tbl_sel", {8'h00, bus.periph_sel}, {8'h00, tbl[i].sel});
        end

        // Internal clock, bypass, write inhibit and overflow
        wr(9'h081, 8'h08);
        wr(9'h001, 8'hFD);
        for (int i = 0; i < 6; i++) begin
            cycle(9'h001, 8'h00, 1'b0, 1'b1, 1'b0);
            chk("ovf_tmr0", {1'b0, bus.periph_rd_data}, {1'b0, e2[i]});
            chk("ovf_t0if", {8'h00, t0if_set}, (i == 4) ? 9'h001 : 9'h000);
            repeat (3) cycle(9'h001, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // Prescaler 1:4 and phase reset on OPTION write
        wr(9'h081, 8'h01);
        wr(9'h001, 8'h00);
        icyc(10);
        chk("presc_1to4", {1'b0, bus.periph_rd_data}, 9'h002);
        wr(9'h001, 8'h00);
        icyc(5);
        chk("presc_phase_pre", {1'b0, bus.periph_rd_data}, 9'h000);
        wr(9'h181, 8'h01);
        icyc(4);
        chk("presc_phase_post", {1'b0, bus.periph_rd_data}, 9'h001);

        // Pin, rising edges, bypass
        wr(9'h081, 8'h28);
        wr(9'h001, 8'h00);
        icyc(2);
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 10; j++) begin
                cycle(9'h001, 8'h00, 1'b0, 1'b0, j < 5);
                if (p == 0 && j <= 2)
                    chk("pin_latency", {1'b0, bus.periph_rd_data}, (j == 2) ? 9'h001 : 9'h000);
            end
        end
        chk("pin_rise_count", {1'b0, bus.periph_rd_data}, 9'h005);

        // Pin, falling edges
        wr(9'h081, 8'h38);
        wr(9'h001, 8'h00);
        icyc(2);
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 10; j++) begin
                cycle(9'h001, 8'h00, 1'b0, 1'b0, j < 5);
                if (p == 0 && j == 4)
                    chk("pin_fall_norise", {1'b0, bus.periph_rd_data}, 9'h000);
            end
        end
        chk("pin_fall_count", {1'b0, bus.periph_rd_data}, 9'h003);

        // Pin held high through reset release
        do_reset(1'b1);
        repeat (10) cycle(9'h001, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("pin_high_reset", {1'b0, bus.periph_rd_data}, 9'h000);

        // Randomized traffic against the model
        do_reset(1'b0);
        rpin = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: ra = 9'h001;
                1: ra = 9'h101;
                2: ra = 9'h081;
                3: ra = 9'h181;
                default: ra = 9'($urandom_range(0, 511));
            endcase
            rwd = $urandom_range(0, 1) ? (8'hF0 | 8'($urandom_range(0, 15))) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rpin = ~rpin;
            cycle(ra, rwd, $urandom_range(0, 15) == 0, (i % 4) == 0 || $urandom_range(0, 9) == 0, rpin);
        end

        // Asynchronous reset mid-count
        wr(9'h081, 8'h08);
        wr(9'h001, 8'h7F);
        icyc(3);
        chk("pre_async_tmr0", {1'b0, bus.periph_rd_data}, 9'h080);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_tmr0", {1'b0, bus.periph_rd_data}, 9'h000);
        bus.periph_addr = 9'h081;
        #1;
        chk("async_option", {1'b0, bus.periph_rd_data}, 9'h0FF);
        chk("async_sel", {8'h00, bus.periph_sel}, 9'h001);
        chk("async_t0if", {8'h00, t0if_set}, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
